toggle_cover_detect: RTL
========================

// Module: toggle_cover_detect
// PURPOSE
//  Edge detector feeding the per-group toggle coverage reporter (DPI, COVER_INDEX+k).
//  Samples a W-bit design signal each cycle and flags rising/falling transitions per bit.
//  Emits a registered one-cycle valid vector of 2*W cover points straight into the reporter's valid input.
//  Keeps a sticky "seen" bitmap plus a distinct-point counter for on-chip coverage readout.
// PARAMETERS
//  W        7   width of the monitored signal; cover points = 2*W
//  CNT_W    $clog2(2*W+1)   width of covered_cnt (derived, not overridden)
// PORTS
//  clock        in   1       single clock, all state on posedge
//  reset        in   1       synchronous, active-high
//  en           in   1       detection enable; 0 = sample but do not report or count
//  clear        in   1       synchronous re-arm of seen bitmap and counter
//  sig          in   W       monitored signal
//  valid        out  2*W     one-cycle cover pulses; [2i]=bit i rose, [2i+1]=bit i fell
//  covered_cnt  out  CNT_W   number of distinct cover points seen since reset/clear
//  all_covered  out  1       high while covered_cnt == 2*W
// BEHAVIOUR
//  State: prev_q[W], prev_vld (1b), seen_q[2W], valid_q[2W], cnt_q[CNT_W].
//  Reset (reset=1 at posedge): prev_vld=0, prev_q=0, seen_q=0, valid_q=0, cnt_q=0;
//   so valid=0, covered_cnt=0, all_covered=0 in the cycle after reset.
//  prev_q<=sig every non-reset cycle, regardless of en/clear; prev_vld<=1.
//  Combinational at cycle n: rise[i]=sig[i]&~prev_q[i]; fall[i]=~sig[i]&prev_q[i];
//   hit[2i]=rise[i], hit[2i+1]=fall[i]; hit forced 0 when !prev_vld or !en.
//  First cycle after reset deassertion only loads prev_q: no spurious edge from reset value.
//  Latency: edge visible in sig at cycle n -> valid bit high in cycle n+1 for exactly one cycle.
//  new_hit = hit & ~seen_q; seen_q <= seen_q | hit; cnt_q <= cnt_q + popcount(new_hit).
//  cnt_q cannot exceed 2*W (distinct points only); no wrap logic required, saturation implicit.
//  Multiple bits may toggle in one cycle: all corresponding valid bits set together,
//   count increments by the number of new points (up to 2*W in one cycle).
//  clear=1 (not reset): seen_q<=0, cnt_q<=0, valid_q<=0; clear beats hit in the same cycle
//   (that cycle's edges are neither reported nor counted); prev_q still updates.
//  en=0: valid_q<=0, seen_q/cnt_q hold; prev_q tracks sig so re-enable yields no false edge.
//  all_covered is combinational from cnt_q (no extra latency vs covered_cnt).
//  No backpressure: downstream reporter consumes every cycle; pulses are never buffered.
// CONFIGURATION
//  TOGGLE_COVER_FIRST_ONLY_EN defined: valid_q <= new_hit (each point reported once until clear).
//  Not defined: valid_q <= hit (every qualifying toggle reported).
//  seen_q, covered_cnt, all_covered behave identically in both builds.
// TESTING
//  1 reset, sig=7'h00 held 20 cycles -> valid=0, covered_cnt=0, all_covered=0 throughout.
//  2 reset released with sig=7'h7F, held -> no valid pulse in any cycle (prev_vld gating).
//  3 sig 7'h00->7'h01 at cycle k -> valid=14'h0001 at k+1 only, covered_cnt=1 at k+1.
//  4 then 7'h01->7'h00 -> valid=14'h0002, cnt=2; repeat 0->1: FIRST_ONLY build valid=0, cnt=2;
//    default build valid=14'h0001, cnt=2.
//  5 sig 7'h00->7'h7F->7'h00 -> valid 14'h1555 then 14'h2AAA, cnt=14, all_covered=1;
//    then clear=1 with sig->7'h7F same cycle -> next cycle valid=0, cnt=0, all_covered=0.
//  6 en=0 while sig toggles 7'h00->7'h08 -> valid=0, cnt unchanged; en=1 with sig steady ->
//    no pulse; next change 7'h08->7'h00 -> valid=14'h0080.

Source files
------------

// File: rtl/toggle_cover_detect.sv
// Per-bit rise/fall edge detector driving toggle cover points, with sticky seen map and distinct-point count.
// Optional build macro TOGGLE_COVER_FIRST_ONLY_EN: report each cover point only once until clear.
module toggle_cover_detect #(
  parameter int unsigned W = 7
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            en,
  input  logic                            clear,
  input  logic [W-1:0]                    sig,
  output logic [2*W-1:0]                  valid,
  output logic [$clog2(2*W+1)-1:0]        covered_cnt,
  output logic                            all_covered
);

  localparam int unsigned NPTS  = 2 * W;
  localparam int unsigned CNT_W = $clog2(2 * W + 1);

  logic [W-1:0]     prev_q;
  logic             prev_vld;
  logic [NPTS-1:0]  seen_q;
  logic [NPTS-1:0]  valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic [NPTS-1:0]  hit;
  logic [NPTS-1:0]  new_hit;
  logic [CNT_W-1:0] new_cnt;

  // Edge detect against last sample; gated until a real sample exists and while disabled.
  always_comb begin
    hit     = '0;
    new_hit = '0;
    new_cnt = '0;
    for (int i = 0; i < int'(W); i++) begin
      hit[2*i]   = sig[i] & ~prev_q[i];
      hit[2*i+1] = ~sig[i] & prev_q[i];
    end
    if (!prev_vld || !en) begin
      hit = '0;
    end
    new_hit = hit & ~seen_q;
    for (int j = 0; j < int'(NPTS); j++) begin
      new_cnt = new_cnt + CNT_W'(new_hit[j]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q   <= '0;
      prev_vld <= 1'b0;
      seen_q   <= '0;
      valid_q  <= '0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= sig;
      prev_vld <= 1'b1;
      if (clear) begin
        seen_q  <= '0;
        valid_q <= '0;
        cnt_q   <= '0;
      end else begin
`ifdef TOGGLE_COVER_FIRST_ONLY_EN
        valid_q <= new_hit;
`else
        valid_q <= hit;
`endif
        seen_q  <= seen_q | hit;
        cnt_q   <= cnt_q + new_cnt;
      end
    end
  end

  assign valid       = valid_q;
  assign covered_cnt = cnt_q;
  assign all_covered = (cnt_q == CNT_W'(NPTS));

endmodule
